issue_ctrl: RTL and testbench
=============================

// Module: issue_ctrl
// PURPOSE
//  Issue-stage controller at the read end of the instruction buffer. Examines the two head entries,
//  decides no/single/dual issue, drives the pop request back to the buffer, and registers issued
//  instructions into the two ID-stage pipeline slots. Enforces pairing, load-use and delay-slot rules.
// PARAMETERS
//  ADDR_W   32  width of instruction address (pc)
//  INST_W   32  width of instruction word
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous reset, active-high
//  flush           in   1       pipeline flush (branch redirect / exception)
//  stall           in   1       downstream stall; hold ID slots, pop nothing
//  buf_inst1_i     in   INST_W  buffer head instruction
//  buf_inst2_i     in   INST_W  buffer head+1 instruction
//  buf_addr1_i     in   ADDR_W  pc of head
//  buf_addr2_i     in   ADDR_W  pc of head+1
//  buf_valid1_i    in   1       head entry valid
//  buf_valid2_i    in   1       head+1 entry valid
//  issue_o         out  1       pop request to buffer this cycle
//  issue_mode_o    out  1       0 = pop one (single), 1 = pop two (dual)
//  id_inst1_o      out  INST_W  ID slot 1 instruction (registered)
//  id_addr1_o      out  ADDR_W  ID slot 1 pc
//  id_valid1_o     out  1       ID slot 1 valid
//  id_ds1_o        out  1       ID slot 1 is a branch delay slot
//  id_inst2_o      out  INST_W  ID slot 2 instruction
//  id_addr2_o      out  ADDR_W  ID slot 2 pc
//  id_valid2_o     out  1       ID slot 2 valid
//  id_ds2_o        out  1       ID slot 2 is a branch delay slot
// BEHAVIOUR
//  Decode (MIPS32, comb): op=[31:26] rs=[25:21] rt=[20:16] rd=[15:11] funct=[5:0].
//   dest: op=0 -> rd; op 0x08-0x0F or 0x20-0x25 -> rt; op=0x03 (JAL) -> 31; else none. dest 0 = none.
//   branch: op 0x01-0x07, or op=0 with funct 0x08/0x09. load: op 0x20-0x25. mem: op 0x20-0x2B.
//   hilo: op=0, funct 0x10-0x1B. priv: op=0x10, or op=0 with funct 0x0C/0x0D.
//  Dual legal iff: valid1 & valid2; inst2 not branch, not priv; inst1 not priv; not (mem1 & mem2);
//   not (hilo1 & hilo2); not RAW (dest1!=0 and dest1 equals rs2 or rt2).
//  Load-use: last_ld_dest register holds dest of the load issued last cycle (0 if none). If inst1 reads
//   it -> issue nothing this cycle; if only inst2 reads it -> single issue (inst1 only).
//  State: NORMAL, DS_PEND.
//   NORMAL, inst1 branch: valid2=0 -> issue nothing (wait for slot); dual legal -> dual, id_ds2=1;
//    else single, go DS_PEND. DS_PEND: next issued inst1 gets id_ds1=1 (single issue only), back to NORMAL.
//   Branch never issued alone in NORMAL when its slot is dual-legal.
//  issue_o/issue_mode_o combinational: 0 when rst, flush, stall, valid1=0 or hold condition.
//   issue_mode_o=0 whenever issue_o=0.
//  ID regs update on clk: rst|flush -> all valid/ds = 0, inst/addr = 0, state NORMAL, last_ld_dest=0.
//   stall -> hold all. issue single -> slot1 = head, valid2=0. dual -> both. none -> valid1=valid2=0.
//  Latency: head visible at cycle N -> ID slot valid at N+1. Flush has priority over stall and issue.
//  last_ld_dest updates only on issue (last issued load's dest); cleared on non-issuing cycle not stalled.
//  Reset outputs: issue_o=0, issue_mode_o=0, all id_* = 0.
// TESTING
//  1. addu $3,$1,$2 + addu $5,$4,$4 both valid -> issue_o=1, mode=1; next cycle valid1=valid2=1, ds=0.
//  2. addu $3,$1,$2 + addu $5,$3,$4 (RAW) -> mode=0; slot1=first, valid2=0; next cycle second issues.
//  3. beq head, valid2=0 -> issue_o=0; next cycle slot arrives -> dual, id_ds2=1.
//  4. lw $8,0($1) issued, then addu $9,$8,$2 at head -> issue_o=0 one cycle, then single/dual issue.
//  5. lw + sw pair -> single issue; stall=1 mid-stream -> issue_o=0, ID slots unchanged.
//  6. flush with DS_PEND and valid slots -> next cycle all id_valid=0, state NORMAL, ds flags 0.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue-stage controller: inspects the two instruction-buffer head entries, decides
// no/single/dual issue, pops the buffer and registers issued instructions into the ID slots.
module issue_ctrl #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic [INST_W-1:0] buf_inst1_i,
   input  logic [INST_W-1:0] buf_inst2_i,
   input  logic [ADDR_W-1:0] buf_addr1_i,
   input  logic [ADDR_W-1:0] buf_addr2_i,
   input  logic              buf_valid1_i,
   input  logic              buf_valid2_i,
   output logic              issue_o,
   output logic              issue_mode_o,
   output logic [INST_W-1:0] id_inst1_o,
   output logic [ADDR_W-1:0] id_addr1_o,
   output logic              id_valid1_o,
   output logic              id_ds1_o,
   output logic [INST_W-1:0] id_inst2_o,
   output logic [ADDR_W-1:0] id_addr2_o,
   output logic              id_valid2_o,
   output logic              id_ds2_o
);

   typedef enum logic {
      NORMAL  = 1'b0,
      DS_PEND = 1'b1
   } state_t;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dest;
      logic       br;
      logic       ld;
      logic       mem;
      logic       hilo;
      logic       priv;
   } dec_t;

   // Classifies a MIPS32 word; dest of 0 means the instruction writes no register.
   function automatic dec_t decode(input logic [31:0] w);
      dec_t       d;
      logic [5:0] op;
      logic [5:0] fn;
      op     = w[31:26];
      fn     = w[5:0];
      d.rs   = w[25:21];
      d.rt   = w[20:16];
      d.dest = 5'd0;
      if (op == 6'h00)
         d.dest = w[15:11];
      else if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h25))
         d.dest = w[20:16];
      else if (op == 6'h03)
         d.dest = 5'd31;
      d.br   = (op >= 6'h01 && op <= 6'h07) || (op == 6'h00 && (fn == 6'h08 || fn == 6'h09));
      d.ld   = (op >= 6'h20 && op <= 6'h25);
      d.mem  = (op >= 6'h20 && op <= 6'h2B);
      d.hilo = (op == 6'h00) && (fn >= 6'h10 && fn <= 6'h1B);
      d.priv = (op == 6'h10) || (op == 6'h00 && (fn == 6'h0C || fn == 6'h0D));
      return d;
   endfunction

   state_t     state;
   logic [4:0] last_ld_dest;

   dec_t       dec1;
   dec_t       dec2;
   logic       raw;
   logic       dual_legal;
   logic       lu1;
   logic       lu2;
   logic       hold;
   logic       can_dual;
   logic [4:0] issue_ld_dest;

   always_comb begin
      dec1 = decode(buf_inst1_i[31:0]);
      dec2 = decode(buf_inst2_i[31:0]);
   end

   always_comb begin
      raw        = (dec1.dest != 5'd0) && (dec1.dest == dec2.rs || dec1.dest == dec2.rt);
      dual_legal = buf_valid1_i && buf_valid2_i && !dec2.br && !dec2.priv && !dec1.priv &&
                   !(dec1.mem && dec2.mem) && !(dec1.hilo && dec2.hilo) && !raw;
      lu1        = (last_ld_dest != 5'd0) &&
                   (dec1.rs == last_ld_dest || dec1.rt == last_ld_dest);
      lu2        = buf_valid2_i && (last_ld_dest != 5'd0) &&
                   (dec2.rs == last_ld_dest || dec2.rt == last_ld_dest);
      // A branch in NORMAL waits until its delay slot is visible so the pair can be judged.
      hold       = lu1 || (state == NORMAL && dec1.br && !buf_valid2_i);
      can_dual   = dual_legal && !lu2 && (state == NORMAL);
   end

   always_comb begin
      issue_o      = !rst && !flush && !stall && buf_valid1_i && !hold;
      issue_mode_o = issue_o && can_dual;
   end

   // Youngest issued load wins, so a dual issue prefers slot 2's load.
   always_comb begin
      issue_ld_dest = 5'd0;
      if (issue_mode_o && dec2.ld)
         issue_ld_dest = dec2.dest;
      else if (dec1.ld)
         issue_ld_dest = dec1.dest;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state        <= NORMAL;
         last_ld_dest <= 5'd0;
         id_inst1_o   <= '0;
         id_addr1_o   <= '0;
         id_valid1_o  <= 1'b0;
         id_ds1_o     <= 1'b0;
         id_inst2_o   <= '0;
         id_addr2_o   <= '0;
         id_valid2_o  <= 1'b0;
         id_ds2_o     <= 1'b0;
      end else if (!stall) begin
         if (issue_o) begin
            id_inst1_o   <= buf_inst1_i;
            id_addr1_o   <= buf_addr1_i;
            id_valid1_o  <= 1'b1;
            id_ds1_o     <= (state == DS_PEND);
            last_ld_dest <= issue_ld_dest;
            if (issue_mode_o) begin
               id_inst2_o  <= buf_inst2_i;
               id_addr2_o  <= buf_addr2_i;
               id_valid2_o <= 1'b1;
               id_ds2_o    <= dec1.br;
            end else begin
               id_inst2_o  <= '0;
               id_addr2_o  <= '0;
               id_valid2_o <= 1'b0;
               id_ds2_o    <= 1'b0;
            end
            if (state == DS_PEND)
               state <= NORMAL;
            else if (dec1.br && !issue_mode_o)
               state <= DS_PEND;
         end else begin
            last_ld_dest <= 5'd0;
            id_inst1_o   <= '0;
            id_addr1_o   <= '0;
            id_valid1_o  <= 1'b0;
            id_ds1_o     <= 1'b0;
            id_inst2_o   <= '0;
            id_addr2_o   <= '0;
            id_valid2_o  <= 1'b0;
            id_ds2_o     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: the driver queues expected issue decisions and ID-slot
// contents; a negedge monitor pops and compares them when each becomes due.
module tb_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        stall;
   logic [31:0] buf_inst1_i;
   logic [31:0] buf_inst2_i;
   logic [31:0] buf_addr1_i;
   logic [31:0] buf_addr2_i;
   logic        buf_valid1_i;
   logic        buf_valid2_i;
   logic        issue_o;
   logic        issue_mode_o;
   logic [31:0] id_inst1_o;
   logic [31:0] id_addr1_o;
   logic        id_valid1_o;
   logic        id_ds1_o;
   logic [31:0] id_inst2_o;
   logic [31:0] id_addr2_o;
   logic        id_valid2_o;
   logic        id_ds2_o;

   issue_ctrl #(.ADDR_W(32), .INST_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .buf_inst1_i(buf_inst1_i), .buf_inst2_i(buf_inst2_i),
      .buf_addr1_i(buf_addr1_i), .buf_addr2_i(buf_addr2_i),
      .buf_valid1_i(buf_valid1_i), .buf_valid2_i(buf_valid2_i),
      .issue_o(issue_o), .issue_mode_o(issue_mode_o),
      .id_inst1_o(id_inst1_o), .id_addr1_o(id_addr1_o),
      .id_valid1_o(id_valid1_o), .id_ds1_o(id_ds1_o),
      .id_inst2_o(id_inst2_o), .id_addr2_o(id_addr2_o),
      .id_valid2_o(id_valid2_o), .id_ds2_o(id_ds2_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   // kind 0: issue_o/issue_mode_o this cycle; kind 1: ID slots after the next edge.
   typedef struct {
      int          due;
      logic        kind;
      logic [1:0]  iss;
      logic [3:0]  flags;   // {valid1, ds1, valid2, ds2}
      logic        full;    // also compare inst/addr of invalid slots (must be zero)
      logic [31:0] i1, a1, i2, a2;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t prev_id;
   int   total = 0;
   int   bad   = 0;
   string tag = "none";

   always @(negedge clk) begin : monitor
      exp_t e;
      logic ok;
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         total++;
         if (e.kind == 1'b0) begin
            if ({issue_o, issue_mode_o} !== e.iss) begin
               bad++;
               $display("FAIL %s issue cyc=%0d: got issue=%b mode=%b want issue=%b mode=%b",
                        e.name, cyc, issue_o, issue_mode_o, e.iss[1], e.iss[0]);
            end
         end else begin
            ok = ({id_valid1_o, id_ds1_o, id_valid2_o, id_ds2_o} === e.flags);
            if ((e.full || e.flags[3]) && {id_inst1_o, id_addr1_o} !== {e.i1, e.a1}) ok = 1'b0;
            if ((e.full || e.flags[1]) && {id_inst2_o, id_addr2_o} !== {e.i2, e.a2}) ok = 1'b0;
            if (!ok) begin
               bad++;
               $display("FAIL %s id_slots cyc=%0d: got v1ds1v2ds2=%b%b%b%b s1=%h@%h s2=%h@%h want %b s1=%h@%h s2=%h@%h",
                        e.name, cyc, id_valid1_o, id_ds1_o, id_valid2_o, id_ds2_o,
                        id_inst1_o, id_addr1_o, id_inst2_o, id_addr2_o,
                        e.flags, e.i1, e.a1, e.i2, e.a2);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic r, input logic f, input logic s,
                       input logic [31:0] i1, input logic [31:0] a1, input logic v1,
                       input logic [31:0] i2, input logic [31:0] a2, input logic v2,
                       input logic e_iss, input logic e_mode,
                       input logic e_v1, input logic e_d1, input logic e_v2, input logic e_d2);
      exp_t c;
      exp_t d;
      @(posedge clk);
      #1;
      rst = r; flush = f; stall = s;
      buf_inst1_i = i1; buf_addr1_i = a1; buf_valid1_i = v1;
      buf_inst2_i = i2; buf_addr2_i = a2; buf_valid2_i = v2;
      c = '{due: cyc, kind: 1'b0, iss: {e_iss, e_mode}, flags: 4'b0, full: 1'b0,
            i1: 32'h0, a1: 32'h0, i2: 32'h0, a2: 32'h0, name: tag};
      exp_q.push_back(c);
      if (s && !r && !f) begin
         d = prev_id;
      end else begin
         d = '{due: 0, kind: 1'b1, iss: 2'b00, flags: {e_v1, e_d1, e_v2, e_d2}, full: r | f,
               i1: e_v1 ? i1 : 32'h0, a1: e_v1 ? a1 : 32'h0,
               i2: e_v2 ? i2 : 32'h0, a2: e_v2 ? a2 : 32'h0, name: tag};
      end
      d.due  = cyc + 1;
      d.name = tag;
      exp_q.push_back(d);
      prev_id = d;
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction
   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] addu(input int rd, input int rs, input int rt);
      return rtype(rs, rt, rd, 'h21);
   endfunction

   logic [31:0] beq_i, lw8_i, sw9_i, sysc_i, mult_i, mfhi_i;

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0;
      buf_inst1_i = '0; buf_inst2_i = '0; buf_addr1_i = '0; buf_addr2_i = '0;
      buf_valid1_i = 1'b0; buf_valid2_i = 1'b0;
      beq_i  = itype('h04, 1, 2, 4);
      lw8_i  = itype('h23, 1, 8, 0);
      sw9_i  = itype('h2B, 1, 9, 4);
      sysc_i = rtype(0, 0, 0, 'h0C);
      mult_i = rtype(1, 2, 0, 'h18);
      mfhi_i = rtype(0, 0, 4, 'h10);

      tag = "reset";
      step(1,0,0, addu(3,1,2),'h100,1, addu(5,4,4),'h104,1, 0,0, 0,0,0,0);
      step(1,0,0, addu(3,1,2),'h100,1, addu(5,4,4),'h104,1, 0,0, 0,0,0,0);

      tag = "dual";
      step(0,0,0, addu(3,1,2),'h100,1, addu(5,4,4),'h104,1, 1,1, 1,0,1,0);

      tag = "raw";
      step(0,0,0, addu(3,1,2),'h108,1, addu(5,3,4),'h10c,1, 1,0, 1,0,0,0);
      step(0,0,0, addu(5,3,4),'h10c,1, addu(6,1,1),'h110,1, 1,1, 1,0,1,0);

      tag = "br_wait";
      step(0,0,0, beq_i,'h200,1, 32'h0,'h0,0, 0,0, 0,0,0,0);
      step(0,0,0, beq_i,'h200,1, addu(7,1,2),'h204,1, 1,1, 1,0,1,1);

      tag = "load_use";
      step(0,0,0, lw8_i,'h300,1, addu(9,8,2),'h304,1, 1,0, 1,0,0,0);
      step(0,0,0, addu(9,8,2),'h304,1, addu(10,1,1),'h308,1, 0,0, 0,0,0,0);
      step(0,0,0, addu(9,8,2),'h304,1, addu(10,1,1),'h308,1, 1,1, 1,0,1,0);

      tag = "lu_slot2";
      step(0,0,0, lw8_i,'h400,1, addu(11,1,2),'h404,1, 1,1, 1,0,1,0);
      step(0,0,0, addu(12,1,2),'h408,1, addu(13,8,1),'h40c,1, 1,0, 1,0,0,0);
      step(0,0,0, addu(13,8,1),'h40c,1, 32'h0,'h0,0, 1,0, 1,0,0,0);

      tag = "mem_stall";
      step(0,0,0, lw8_i,'h500,1, sw9_i,'h504,1, 1,0, 1,0,0,0);
      step(0,0,1, sw9_i,'h504,1, addu(14,8,1),'h508,1, 0,0, 0,0,0,0);
      step(0,0,0, sw9_i,'h504,1, addu(14,8,1),'h508,1, 1,0, 1,0,0,0);
      step(0,0,0, addu(14,8,1),'h508,1, 32'h0,'h0,0, 1,0, 1,0,0,0);

      tag = "flush";
      step(0,0,0, beq_i,'h600,1, sysc_i,'h604,1, 1,0, 1,0,0,0);
      step(0,1,1, sysc_i,'h604,1, 32'h0,'h0,0, 0,0, 0,0,0,0);
      step(0,0,0, addu(3,1,2),'h700,1, 32'h0,'h0,0, 1,0, 1,0,0,0);

      tag = "ds_pend";
      step(0,0,0, lw8_i,'h7f8,1, 32'h0,'h0,0, 1,0, 1,0,0,0);
      step(0,0,0, beq_i,'h800,1, addu(15,8,1),'h804,1, 1,0, 1,0,0,0);
      step(0,0,0, addu(15,8,1),'h804,1, addu(16,1,2),'h808,1, 1,0, 1,1,0,0);
      step(0,0,0, addu(16,1,2),'h808,1, 32'h0,'h0,0, 1,0, 1,0,0,0);

      tag = "priv_hilo";
      step(0,0,0, sysc_i,'h900,1, addu(17,1,2),'h904,1, 1,0, 1,0,0,0);
      step(0,0,0, mult_i,'ha00,1, mfhi_i,'ha04,1, 1,0, 1,0,0,0);
      step(0,0,0, mfhi_i,'ha04,1, 32'h0,'h0,0, 1,0, 1,0,0,0);

      tag = "idle";
      step(0,0,0, 32'h0,'h0,0, addu(18,1,2),'hb04,1, 0,0, 0,0,0,0);
      step(0,0,0, 32'h0,'h0,0, 32'h0,'h0,0, 0,0, 0,0,0,0);

      for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
